fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  IF stage of the 5-stage RV32I pipeline. Holds the PC, drives the instruction-memory address, and
//  owns the IF/ID pipeline register. It consumes the stall/flush decisions of the hazard unit
//  (pc_write, if_id_write, if_flush) and the EX-stage redirect. Also sequences the ECALL halt drain
//  and keeps saturating stall/flush performance counters.
// PARAMETERS
//  RESET_PC      32'h0000_0000  PC value loaded on reset
//  DRAIN_CYCLES  4              bubble cycles issued after halt_req before entering HALTED (1..15)
//  CNT_W         16             width of stall_count / flush_count
// PORTS
//  clk              in   1      rising-edge clock
//  reset            in   1      asynchronous, active-high reset
//  pc_write         in   1      hazard unit: 1 = PC may advance, 0 = hold PC (load-use / ecall stall)
//  if_id_write      in   1      hazard unit: 1 = IF/ID may load, 0 = hold IF/ID contents
//  if_flush         in   1      hazard unit: squash the IF/ID entry (taken branch / jal / jalr)
//  redirect_valid   in   1      EX: control transfer resolved, redirect_target is valid
//  redirect_target  in   32     EX: next PC on redirect (bit 1:0 forced to 0 when used)
//  halt_req         in   1      WB: ECALL halt (x17 == 10) retiring this cycle
//  imem_inst        in   32     combinational instruction read at imem_addr
//  imem_addr        out  32     current PC
//  if_id_pc         out  32     PC of the instruction held in IF/ID
//  if_id_inst       out  32     instruction held in IF/ID (NOP when invalid)
//  if_id_valid      out  1      IF/ID holds a real instruction
//  halted           out  1      pipeline drained after halt; PC frozen
//  stall_count      out  CNT_W  cycles in which the fetch stage stalled (saturating)
//  flush_count      out  CNT_W  cycles with if_flush asserted in RUN (saturating)
// BEHAVIOUR
//  - Reset (async, immediate): PC=RESET_PC, if_id_pc=0, if_id_inst=NOP(32'h0000_0013),
//    if_id_valid=0, state=RUN, drain counter=0, halted=0, both counters=0. Reset mid-drain/halt aborts to RUN.
//  - Single-cycle fetch: imem_addr = PC combinationally; the IF/ID register captures imem_inst and PC
//    at the next edge, so latency from PC to if_id_inst is 1 cycle.
//  - FSM: RUN -> DRAIN on halt_req; DRAIN -> HALTED when drain counter reaches DRAIN_CYCLES-1;
//    HALTED is absorbing until reset. halt_req in DRAIN or HALTED is ignored.
//  - PC next-value priority (per edge, RUN only):
//      1 halt_req -> hold PC      2 redirect_valid -> {redirect_target[31:2],2'b00}
//      3 !pc_write -> hold PC     4 else PC+4 (32-bit wrap, 32'hFFFF_FFFC+4 = 0)
//    A redirect overrides a simultaneous stall: the stalled ID instruction is on the wrong path.
//  - IF/ID priority (RUN): halt_req or if_flush or redirect_valid -> valid=0, inst=NOP, pc=PC;
//    else !if_id_write -> hold all three; else load {PC, imem_inst}, valid=1.
//  - DRAIN/HALTED: PC held; IF/ID is forced to NOP/invalid every cycle; pc_write, if_id_write,
//    if_flush and redirect_valid are all ignored.
//  - halted=1 only in HALTED (registered, asserted one cycle after the final drain bubble).
//  - stall_count += 1 per RUN cycle with !pc_write && !redirect_valid && !halt_req.
//    flush_count += 1 per RUN cycle with if_flush. Both saturate at all-ones, with no wrap.
//  - pc_write=1 with if_id_write=0 is illegal from the hazard unit; fetch_stage behaves per priority
//    (PC advances, IF/ID holds), and an assertion flags the combination in simulation.
// STRUCTURE
//  - Shared package fetch_pkg: localparam NOP_INST = 32'h0000_0013; FSM state encoding
//    (S_RUN=2'd0, S_DRAIN=2'd1, S_HALTED=2'd2); the XLEN=32 constant.
//  - One sub-module: if_id_register (async-reset, write-enable + flush, carries pc/inst/valid).
//    PC register, next-PC mux, FSM and counters stay in fetch_stage.
// TESTING
//  1 Reset with RESET_PC=0x100 -> imem_addr=0x100, if_id_valid=0; 3 free cycles -> if_id_pc 0x100,0x104,0x108.
//  2 Load-use: pc_write=if_id_write=0 for 1 cycle at PC=0x20 -> PC stays 0x20, IF/ID holds, stall_count=1.
//  3 Redirect 0x400 with pc_write=0 and if_flush=1 in the same cycle -> next PC=0x400, IF/ID=NOP/invalid,
//    flush_count+1, stall_count unchanged.
//  4 halt_req at PC=0x40 with DRAIN_CYCLES=4 -> PC frozen at 0x40, 4 NOP bubbles, halted=1 on the
//    5th edge; a later redirect_valid is ignored.
//  5 PC=0xFFFF_FFFC, free-running -> next PC=0x0000_0000; redirect_target=0x203 -> PC=0x200.
//  6 Counter saturation (CNT_W=4, 20 stall cycles) -> stall_count=0xF; async reset asserted mid-DRAIN
//    -> all outputs reach reset values before the next clock edge.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared constants and types for the RV32I instruction-fetch stage.
package fetch_pkg;

    localparam int          XLEN     = 32;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_DRAIN  = 2'd1,
        S_HALTED = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register: flush squashes to an invalid NOP, otherwise load-enabled capture.
module if_id_register
    import fetch_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            load_i,
    input  logic            flush_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] inst_i,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] inst_o,
    output logic            valid_o
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] inst_q;
    logic            valid_q;

    // A squashed slot still records the PC it replaced, which helps when tracing bubbles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q    <= '0;
            inst_q  <= NOP_INST;
            valid_q <= 1'b0;
        end else if (flush_i) begin
            pc_q    <= pc_i;
            inst_q  <= NOP_INST;
            valid_q <= 1'b0;
        end else if (load_i) begin
            pc_q    <= pc_i;
            inst_q  <= inst_i;
            valid_q <= 1'b1;
        end
    end

    assign pc_o    = pc_q;
    assign inst_o  = inst_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC register, next-PC selection, IF/ID register, ECALL halt drain and
// saturating stall/flush performance counters.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          DRAIN_CYCLES = 4,
    parameter int          CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pc_write,
    input  logic             if_id_write,
    input  logic             if_flush,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_target,
    input  logic             halt_req,
    input  logic [XLEN-1:0]  imem_inst,
    output logic [XLEN-1:0]  imem_addr,
    output logic [XLEN-1:0]  if_id_pc,
    output logic [XLEN-1:0]  if_id_inst,
    output logic             if_id_valid,
    output logic             halted,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYCLES - 1);

    fetch_state_t    state_q, state_d;
    logic [3:0]      drain_q, drain_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            halted_q;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;
    logic            ifid_load;
    logic            ifid_flush;
    logic            stall_inc;
    logic            flush_inc;

    always_comb begin
        state_d    = state_q;
        drain_d    = drain_q;
        pc_d       = pc_q;
        ifid_load  = 1'b0;
        ifid_flush = 1'b1;
        stall_inc  = 1'b0;
        flush_inc  = 1'b0;
        case (state_q)
            S_RUN: begin
                drain_d    = '0;
                ifid_flush = halt_req | if_flush | redirect_valid;
                ifid_load  = if_id_write;
                stall_inc  = !pc_write && !redirect_valid && !halt_req;
                flush_inc  = if_flush;
                // Redirect beats a stall: the stalled ID instruction is on the wrong path.
                if (halt_req) begin
                    state_d = S_DRAIN;
                end else if (redirect_valid) begin
                    pc_d = {redirect_target[XLEN-1:2], 2'b00};
                end else if (pc_write) begin
                    pc_d = pc_q + 32'd4;
                end
            end
            S_DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    state_d = S_HALTED;
                end else begin
                    drain_d = drain_q + 4'd1;
                end
            end
            S_HALTED: begin
                state_d = S_HALTED;
            end
            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    assign stall_d = (stall_inc && (stall_q != '1)) ? stall_q + 1'b1 : stall_q;
    assign flush_d = (flush_inc && (flush_q != '1)) ? flush_q + 1'b1 : flush_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_RUN;
            drain_q  <= '0;
            pc_q     <= RESET_PC;
            halted_q <= 1'b0;
            stall_q  <= '0;
            flush_q  <= '0;
        end else begin
            state_q  <= state_d;
            drain_q  <= drain_d;
            pc_q     <= pc_d;
            halted_q <= (state_d == S_HALTED);
            stall_q  <= stall_d;
            flush_q  <= flush_d;
        end
    end

    if_id_register u_if_id (
        .clk     (clk),
        .reset   (reset),
        .load_i  (ifid_load),
        .flush_i (ifid_flush),
        .pc_i    (pc_q),
        .inst_i  (imem_inst),
        .pc_o    (if_id_pc),
        .inst_o  (if_id_inst),
        .valid_o (if_id_valid)
    );

    assign imem_addr   = pc_q;
    assign halted      = halted_q;
    assign stall_count = stall_q;
    assign flush_count = flush_q;

    // The hazard unit never advances the PC while freezing IF/ID.
    a_legal_hazard: assert property (@(posedge clk) disable iff (reset)
        !(pc_write && !if_id_write));

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, hand-written halt/wrap/reset sequences,
// and randomized traffic against a behavioural model.
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam int          DRAIN  = 4;
    localparam int          CW     = 4;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam int          SATMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          pc_write, if_id_write, if_flush, redirect_valid, halt_req;
    logic [31:0]   redirect_target;
    logic [31:0]   imem_inst, imem_addr, if_id_pc, if_id_inst;
    logic          if_id_valid, halted;
    logic [CW-1:0] stall_count, flush_count;

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    logic [31:0] m_pc, m_ifid_pc, m_ifid_inst;
    logic        m_valid;
    int          m_mode;      // 0 = running, 1 = draining, 2 = halted
    int          m_left;      // bubbles still to issue while draining
    int          m_stall, m_flush;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    assign imem_inst = mem_word(imem_addr);

    fetch_stage #(.RESET_PC(RST_PC), .DRAIN_CYCLES(DRAIN), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .pc_write(pc_write), .if_id_write(if_id_write),
        .if_flush(if_flush), .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .halt_req(halt_req), .imem_inst(imem_inst), .imem_addr(imem_addr), .if_id_pc(if_id_pc),
        .if_id_inst(if_id_inst), .if_id_valid(if_id_valid), .halted(halted),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = RST_PC; m_ifid_pc = 0; m_ifid_inst = NOP; m_valid = 0;
        m_mode = 0; m_left = 0; m_stall = 0; m_flush = 0;
    endtask

    task automatic squash();
        m_ifid_pc = m_pc; m_ifid_inst = NOP; m_valid = 0;
    endtask

    task automatic model_edge();
        if (m_mode == 0) begin
            if (!pc_write && !redirect_valid && !halt_req && m_stall < SATMAX) m_stall++;
            if (if_flush && m_flush < SATMAX) m_flush++;
            if (halt_req) begin
                squash();
                m_mode = 1; m_left = DRAIN;
            end else if (redirect_valid) begin
                squash();
                m_pc = redirect_target & 32'hFFFF_FFFC;
            end else begin
                if (if_flush) squash();
                else if (if_id_write) begin
                    m_ifid_pc = m_pc; m_ifid_inst = mem_word(m_pc); m_valid = 1;
                end
                if (pc_write) m_pc = m_pc + 4;
            end
        end else begin
            squash();
            if (m_mode == 1) begin
                m_left--;
                if (m_left == 0) m_mode = 2;
            end
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".addr"},   imem_addr,   m_pc);
        check({tag, ".ifpc"},   if_id_pc,    m_ifid_pc);
        check({tag, ".ifinst"}, if_id_inst,  m_ifid_inst);
        check({tag, ".valid"},  32'(if_id_valid), 32'(m_valid));
        check({tag, ".halted"}, 32'(halted), 32'(m_mode == 2));
        check({tag, ".stall"},  32'(stall_count), 32'(m_stall));
        check({tag, ".flush"},  32'(flush_count), 32'(m_flush));
    endtask

    task automatic drive(input logic pw, input logic iw, input logic fl,
                         input logic rv, input logic [31:0] tg, input logic hr);
        pc_write = pw; if_id_write = iw; if_flush = fl;
        redirect_valid = rv; redirect_target = tg; halt_req = hr;
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_model(tag);
    endtask

    // Asynchronous reset raised between edges; outputs must settle before the next edge.
    task automatic async_reset(input string tag);
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_model(tag);
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    typedef struct {
        logic        pw, iw, fl, rv, hr;
        logic [31:0] tg;
        logic [31:0] e_addr, e_ifpc;
        logic        e_valid;
        int          e_stall, e_flush;
    } vec_t;

    vec_t vecs[9];

    initial begin
        //             pw iw fl rv hr target         addr           ifpc           v  st fl
        vecs[0] = '{1, 1, 0, 0, 0, 32'h0,          32'h0000_0104, 32'h0000_0100, 1, 0, 0};
        vecs[1] = '{1, 1, 0, 0, 0, 32'h0,          32'h0000_0108, 32'h0000_0104, 1, 0, 0};
        vecs[2] = '{1, 1, 0, 0, 0, 32'h0,          32'h0000_010C, 32'h0000_0108, 1, 0, 0};
        vecs[3] = '{1, 1, 1, 1, 0, 32'h0000_001C,  32'h0000_001C, 32'h0000_010C, 0, 0, 1};
        vecs[4] = '{1, 1, 0, 0, 0, 32'h0,          32'h0000_0020, 32'h0000_001C, 1, 0, 1};
        vecs[5] = '{0, 0, 0, 0, 0, 32'h0,          32'h0000_0020, 32'h0000_001C, 1, 1, 1};
        vecs[6] = '{0, 0, 1, 1, 0, 32'h0000_0400,  32'h0000_0400, 32'h0000_0020, 0, 1, 2};
        vecs[7] = '{1, 1, 0, 0, 0, 32'h0,          32'h0000_0404, 32'h0000_0400, 1, 1, 2};
        vecs[8] = '{1, 1, 0, 1, 0, 32'h0000_0203,  32'h0000_0200, 32'h0000_0404, 0, 1, 2};

        reset = 1'b1;
        drive(1, 1, 0, 0, 32'h0, 0);
        #1;
        model_reset();
        check_model("reset");
        check("reset.addr_const", imem_addr, RST_PC);
        @(posedge clk);
        #1 reset = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].pw, vecs[i].iw, vecs[i].fl, vecs[i].rv, vecs[i].tg, vecs[i].hr);
            step($sformatf("vec%0d", i));
            check($sformatf("vec%0d.t_addr", i), imem_addr, vecs[i].e_addr);
            check($sformatf("vec%0d.t_ifpc", i), if_id_pc, vecs[i].e_ifpc);
            check($sformatf("vec%0d.t_valid", i), 32'(if_id_valid), 32'(vecs[i].e_valid));
            check($sformatf("vec%0d.t_inst", i), if_id_inst,
                  vecs[i].e_valid ? mem_word(vecs[i].e_ifpc) : NOP);
            check($sformatf("vec%0d.t_stall", i), 32'(stall_count), 32'(vecs[i].e_stall));
            check($sformatf("vec%0d.t_flush", i), 32'(flush_count), 32'(vecs[i].e_flush));
        end

        // PC wrap past the top of the address space
        drive(1, 1, 0, 1, 32'hFFFF_FFFC, 0);
        step("wrap_redir");
        drive(1, 1, 0, 0, 32'h0, 0);
        step("wrap");
        check("wrap.zero", imem_addr, 32'h0000_0000);

        // Halt drain at PC 0x40; later redirects/flushes must be ignored
        drive(1, 1, 0, 1, 32'h0000_0040, 0);
        step("halt_redir");
        drive(1, 1, 0, 0, 32'h0, 1);
        step("halt_req");
        for (int k = 2; k <= 7; k++) begin
            drive(1, 1, 1, 1, 32'h0000_0800, 0);
            step($sformatf("drain%0d", k));
            check($sformatf("drain%0d.pc", k), imem_addr, 32'h0000_0040);
            check($sformatf("drain%0d.halted", k), 32'(halted), 32'(k >= 5));
            check($sformatf("drain%0d.valid", k), 32'(if_id_valid), 32'd0);
        end

        // Reset in the middle of a drain
        async_reset("rst_after_halt");
        drive(1, 1, 0, 0, 32'h0, 1);
        step("halt2");
        drive(1, 1, 0, 0, 32'h0, 0);
        step("halt2_d1");
        step("halt2_d2");
        async_reset("rst_mid_drain");
        check("rst_mid_drain.halted", 32'(halted), 32'd0);

        // Stall counter saturation
        for (int k = 0; k < 20; k++) begin
            drive(0, 0, 0, 0, 32'h0, 0);
            step("sat");
        end
        check("sat.stall_max", 32'(stall_count), 32'h0000_000F);
        check("sat.pc_held", imem_addr, RST_PC);

        // Randomized legal hazard-unit traffic
        for (int k = 0; k < 600; k++) begin
            if (k % 97 == 96) begin
                async_reset("rnd_rst");
            end else begin
                logic pw, iw;
                pw = ($urandom_range(0, 3) != 0);
                iw = pw ? 1'b1 : 1'($urandom_range(0, 1));
                drive(pw, iw, ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
                      $urandom, ($urandom_range(0, 39) == 0));
                step("rnd");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1);
    end

endmodule
